rainbow_lfsr_checker: RTL and testbench
=======================================

Name: rainbow_lfsr_checker

Overview:
Receive-side checker for the 16-bit rainbow random stream. Consumes the stream serially, one bit per valid cycle, and self-synchronises to the Fibonacci LFSR sequence (taps 15,13,12,10). After synchronising, it predicts every following bit, flags mismatches and counts them. It sits on the consumer side of the random source to qualify the stream during bring-up and in-system self-test.

Parameters:
WIDTH, 16, LFSR length in bits
TAPS, 16'hB400, feedback tap mask (bits 15,13,12,10)
LOCK_COUNT, 32, consecutive correct predictions required to declare lock
LOSS_THRESH, 4, consecutive mispredictions in LOCKED that force return to SEARCH
ERR_CNT_W, 16, error counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
enable  input  1  checker runs when 1; all state frozen when 0
bit_in  input  1  serial stream bit; the newest LFSR output bit
bit_valid  input  1  bit_in qualifier; one bit consumed per cycle with bit_valid=1 and enable=1
clear_counts  input  1  synchronous clear of err_count
locked  output  1  1 while in LOCKED
err_pulse  output  1  one-cycle pulse for each mispredicted bit while LOCKED
err_count  output  ERR_CNT_W  saturating count of mispredicted bits while LOCKED
state  output  2  0=SEARCH, 1=LOCKED (debug visibility)

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low on port reset. It returns the block to SEARCH, clears the shift register sr, fill_cnt, run_cnt and miss_cnt, and drives locked=0, err_pulse=0, err_count=0, state=0.
- Reset mid-operation: identical to reset from power-up. No partial state survives.
- Accepted bit: a cycle with enable=1 and bit_valid=1. When enable=0, all registers hold and err_pulse=0.
- Prediction: pred = XOR-reduce(sr & TAPS), combinational from the current sr. match = (bit_in == pred).
- SEARCH state:
  - Every accepted bit shifts in: sr <= {sr[14:0], bit_in}.
  - fill_cnt counts from 0 up to WIDTH and saturates there. No comparison is made until fill_cnt == WIDTH.
  - Once filled, an accepted bit with match=1 and sr != 0 increments run_cnt.
  - A mismatch, or sr == 0, clears run_cnt. This prevents lock on an all-zero stream.
  - When the accepted bit brings run_cnt to LOCK_COUNT, go to LOCKED. locked=1 on the next cycle.
  - Minimum time to lock from reset is WIDTH+LOCK_COUNT = 48 accepted bits.
- LOCKED state (flywheel):
  - sr <= {sr[14:0], pred}, so received errors do not corrupt the reference sequence.
  - On a mismatch: err_pulse=1 on the following cycle, err_count increments and saturates at all-ones, and miss_cnt increments.
  - On a match: miss_cnt clears.
  - When miss_cnt reaches LOSS_THRESH, go to SEARCH with fill_cnt=0 and run_cnt=0, and sr is kept. locked=0 on the next cycle. The bit that triggers the transition is counted as an error.
- clear_counts:
  - Clears err_count on the next edge and has priority over a simultaneous error, which is then not counted. err_pulse still fires.
  - Does not affect state or lock.
- Register timing: all outputs are registered. Latency from an accepted bit to its err_pulse, locked or state change is exactly 1 cycle.
- Gaps in bit_valid: they stall the checker only. Counters and state are unaffected by idle cycles.

Decomposition:
- Shared package rainbow_pkg: RAINBOW_TAPS=16'hB400, RAINBOW_SEED=16'h5A08, RAINBOW_W=16, and the enum chk_state_t {SEARCH, LOCKED}. The generator side and the bench both import these.
- One sub-module is natural: lfsr_predict. It is combinational, with inputs sr and TAPS and output pred, and is reused by the bench reference model.
- The counters and the FSM stay in the top module.

Test Plan:
- Clean lock: feed the serial output of the LFSR seeded 0x5A08 continuously -> locked rises the cycle after the 48th accepted bit; err_count stays 0 over 10,000 bits.
- Single-bit error: once locked, invert stream bit 200 -> exactly one err_pulse one cycle later; err_count=1; locked stays 1; next 1,000 bits give no further pulses.
- Loss and relock:
  - Invert 4 consecutive bits while locked -> err_count=4; locked=0 the cycle after the 4th flipped bit; state=SEARCH.
  - Clean stream then resumes -> relock after 48 accepted bits (16 fill + 32 matches).
- All-zero and all-one streams: 500 zero bits -> locked never asserts. 500 one bits -> locked never asserts (mismatches clear run_cnt).
- Stall and enable: random bit_valid duty of 30%, plus enable=0 for 50 cycles mid-stream -> same lock point in accepted-bit count as the continuous case; no spurious err_pulse.
- Saturation, clear and reset:
  - With ERR_CNT_W=4, inject 20 isolated errors while locked -> err_count=15.
  - Assert clear_counts on the same cycle as an error -> err_count=0.
  - Assert reset mid-stream -> all outputs 0 immediately, with no clock needed.

Source files
------------

// File: rtl/rainbow_pkg.sv
// Shared constants and types for the rainbow random stream.
// The generator side, the checker and the bench all import these.
package rainbow_pkg;

  localparam int          RAINBOW_W    = 16;
  localparam logic [15:0] RAINBOW_TAPS = 16'hB400;
  localparam logic [15:0] RAINBOW_SEED = 16'h5A08;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

endpackage

// File: rtl/rainbow_lfsr_checker_if.sv
// Serial stream input and status outputs of the rainbow LFSR checker.
interface rainbow_lfsr_checker_if #(
  parameter int ERR_CNT_W = 16
) ();

  // A bit is consumed on every clock edge where enable and bit_valid are both 1;
  // there is no backpressure, the checker is always ready.
  logic                 enable;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 clear_counts;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [1:0]           state;

  modport master (
    output enable, bit_in, bit_valid, clear_counts,
    input  locked, err_pulse, err_count, state
  );

  modport slave (
    input  enable, bit_in, bit_valid, clear_counts,
    output locked, err_pulse, err_count, state
  );

endinterface

// File: rtl/rainbow_lfsr_checker_predict.sv
// Next-bit predictor of a Fibonacci LFSR: parity of the tapped history bits.
module lfsr_predict #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] taps,
  output logic             pred
);

  assign pred = ^(sr & taps);

endmodule

// File: rtl/rainbow_lfsr_checker.sv
// Self-synchronising checker for the rainbow LFSR stream: searches for lock,
// then flywheels on its own prediction and counts mispredicted bits.
module rainbow_lfsr_checker
  import rainbow_pkg::*;
#(
  parameter int               WIDTH       = RAINBOW_W,
  parameter logic [WIDTH-1:0] TAPS        = RAINBOW_TAPS,
  parameter int               LOCK_COUNT  = 32,
  parameter int               LOSS_THRESH = 4,
  parameter int               ERR_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  rainbow_lfsr_checker_if.slave  chk
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WIDTH);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

  chk_state_t           state_q, state_d;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_pulse_q, err_pulse_d;

  logic pred;
  logic match;
  logic accept;
  logic filled;
  logic lock_hit;
  logic loss_hit;

  lfsr_predict #(.WIDTH(WIDTH)) u_predict (
    .sr   (sr_q),
    .taps (TAPS),
    .pred (pred)
  );

  assign accept = chk.enable & chk.bit_valid;
  assign match  = (chk.bit_in == pred);
  assign filled = (fill_q == FILL_MAX);

  // An all-zero history predicts zero forever, so it never counts toward lock.
  assign lock_hit = accept && (state_q == SEARCH) && filled && match &&
                    (sr_q != '0) && (run_q == RUN_LAST);
  assign loss_hit = accept && (state_q == LOCKED) && !match && (miss_q == MISS_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEARCH:  if (lock_hit) state_d = LOCKED;
      LOCKED:  if (loss_hit) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    chk.locked    = (state_q == LOCKED);
    chk.state     = {1'b0, state_q};
    chk.err_pulse = err_pulse_q;
    chk.err_count = err_cnt_q;
  end

  always_comb begin
    sr_d        = sr_q;
    fill_d      = fill_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    if (accept) begin
      if (state_q == SEARCH) begin
        sr_d = {sr_q[WIDTH-2:0], chk.bit_in};
        if (!filled) begin
          fill_d = fill_q + FILL_ONE;
        end else if (match && (sr_q != '0) && !lock_hit) begin
          run_d = run_q + RUN_ONE;
        end else begin
          run_d = '0;
        end
        miss_d = '0;
      end else begin
        // Flywheel: the reference keeps running on its own prediction.
        sr_d = {sr_q[WIDTH-2:0], pred};
        if (!match) begin
          err_pulse_d = 1'b1;
          miss_d      = miss_q + MISS_ONE;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
          miss_d = '0;
        end
        if (loss_hit) begin
          fill_d = '0;
          run_d  = '0;
          miss_d = '0;
        end
      end
    end
    if (chk.enable && chk.clear_counts) err_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q        <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

endmodule

// File: tb/tb_rainbow_lfsr_checker.sv
// Bench for rainbow_lfsr_checker: two instances (16- and 4-bit error counters)
// share one stimulus stream and are compared against a bit-history model.
module tb_rainbow_lfsr_checker;
  import rainbow_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic en_r = 1'b0, bv_r = 1'b0, bi_r = 1'b0, clr_r = 1'b0;

  rainbow_lfsr_checker_if #(.ERR_CNT_W(16)) if16 ();
  rainbow_lfsr_checker_if #(.ERR_CNT_W(4))  if4 ();

  assign if16.enable = en_r;  assign if16.bit_valid = bv_r;
  assign if16.bit_in = bi_r;  assign if16.clear_counts = clr_r;
  assign if4.enable  = en_r;  assign if4.bit_valid  = bv_r;
  assign if4.bit_in  = bi_r;  assign if4.clear_counts  = clr_r;

  rainbow_lfsr_checker #(.ERR_CNT_W(16)) dut16 (.clk(clk), .reset(reset), .chk(if16));
  rainbow_lfsr_checker #(.ERR_CNT_W(4))  dut4  (.clk(clk), .reset(reset), .chk(if4));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: last 16 bits of the reference history, newest at the back
  bit hist[$];
  bit m_locked;
  int m_fill, m_run, m_miss, m_err;
  bit m_pulse;
  logic [15:0] taps_v = RAINBOW_TAPS;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 16; i++) hist.push_back(1'b0);
    m_locked = 0; m_fill = 0; m_run = 0; m_miss = 0; m_err = 0; m_pulse = 0;
  endfunction

  function automatic bit model_pred();
    bit p = 0;
    for (int k = 0; k < 16; k++) if (taps_v[k]) p ^= hist[15 - k];
    return p;
  endfunction

  function automatic bit hist_zero();
    for (int k = 0; k < 16; k++) if (hist[k]) return 0;
    return 1;
  endfunction

  function automatic void model_step(input bit en, input bit v, input bit b, input bit clr);
    bit p, ok;
    m_pulse = 0;
    if (!en) return;
    if (v) begin
      p  = model_pred();
      ok = (b == p);
      if (!m_locked) begin
        if (m_fill < 16) m_fill++;
        else if (ok && !hist_zero()) m_run++;
        else m_run = 0;
        void'(hist.pop_front()); hist.push_back(b);
        if (m_run == 32) begin m_locked = 1; m_run = 0; m_miss = 0; end
      end else begin
        void'(hist.pop_front()); hist.push_back(p);
        if (!ok) begin m_pulse = 1; m_miss++; m_err++; end
        else m_miss = 0;
        if (m_miss == 4) begin m_locked = 0; m_fill = 0; m_run = 0; m_miss = 0; end
      end
    end
    if (clr) m_err = 0;
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, "_locked16"}, 32'(if16.locked),    32'(m_locked));
    check({pfx, "_state16"},  32'(if16.state),     32'(m_locked));
    check({pfx, "_pulse16"},  32'(if16.err_pulse), 32'(m_pulse));
    check({pfx, "_count16"},  32'(if16.err_count), (m_err > 65535) ? 32'd65535 : 32'(m_err));
    check({pfx, "_locked4"},  32'(if4.locked),     32'(m_locked));
    check({pfx, "_pulse4"},   32'(if4.err_pulse),  32'(m_pulse));
    check({pfx, "_count4"},   32'(if4.err_count),  (m_err > 15) ? 32'd15 : 32'(m_err));
  endtask

  // source LFSR and driver tasks
  logic [15:0] g;
  int acc_cnt;
  int pulse_cnt;

  function automatic bit gen_next();
    bit nb = ^(g & RAINBOW_TAPS);
    g = {g[14:0], nb};
    return nb;
  endfunction

  task automatic cycle(input bit en, input bit v, input bit b, input bit clr);
    en_r = en; bv_r = v; bi_r = b; clr_r = clr;
    @(posedge clk);
    model_step(en, v, b, clr);
    if (en && v) acc_cnt++;
    #1;
    if (if16.err_pulse) pulse_cnt++;
    check_outputs("cyc");
  endtask

  task automatic send(input bit flip, input bit clr);
    bit b = gen_next() ^ flip;
    cycle(1'b1, 1'b1, b, clr);
  endtask

  task automatic do_reset();
    reset = 1'b0; en_r = 0; bv_r = 0; bi_r = 0; clr_r = 0;
    #2;
    model_reset();
    check_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    g = RAINBOW_SEED;
  endtask

  // Runs the clean source stream; lock_acc is the accepted-bit count at which
  // locked was first seen (-1 if never within the budget).
  task automatic run_stream(input int n_cyc, input int duty, input int stall_at, output int lock_acc);
    bit en, v;
    acc_cnt  = 0;
    lock_acc = -1;
    for (int i = 0; i < n_cyc; i++) begin
      en = !(stall_at >= 0 && i >= stall_at && i < stall_at + 50);
      v  = ($urandom_range(99) < duty);
      if (en && v) cycle(1'b1, 1'b1, gen_next(), 1'b0);
      else cycle(en, v, 1'($urandom_range(1)), 1'b0);
      if (if16.locked && lock_acc < 0) lock_acc = acc_cnt;
    end
  endtask

  int lock_acc;
  bit seen_lock;

  initial begin
    #1;
    do_reset();

    // clean lock and long clean run
    run_stream(10000, 100, -1, lock_acc);
    check("clean_lock_point", 32'(lock_acc), 32'd48);
    check("clean_err_count", 32'(if16.err_count), 32'd0);

    // single flipped bit
    pulse_cnt = 0;
    send(1'b1, 1'b0);
    check("single_count", 32'(if16.err_count), 32'd1);
    for (int i = 0; i < 1000; i++) send(1'b0, 1'b0);
    check("single_pulses", 32'(pulse_cnt), 32'd1);
    check("single_locked", 32'(if16.locked), 32'd1);

    // four consecutive flips force loss, then relock
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    check("loss_count", 32'(if16.err_count), 32'd5);
    check("loss_locked", 32'(if16.locked), 32'd0);
    check("loss_state", 32'(if16.state), 32'd0);
    run_stream(200, 100, -1, lock_acc);
    check("relock_point", 32'(lock_acc), 32'd48);

    // clear_counts beats a simultaneous error
    send(1'b1, 1'b1);
    check("clr_count16", 32'(if16.err_count), 32'd0);
    check("clr_count4", 32'(if4.err_count), 32'd0);
    check("clr_pulse", 32'(if16.err_pulse), 32'd1);

    // saturation with isolated errors
    for (int e = 0; e < 20; e++) begin
      send(1'b1, 1'b0);
      for (int i = 0; i < 5 + $urandom_range(15); i++) send(1'b0, 1'b0);
    end
    check("sat_count4", 32'(if4.err_count), 32'd15);
    check("sat_count16", 32'(if16.err_count), 32'd20);
    check("sat_locked", 32'(if16.locked), 32'd1);

    // reset mid-stream, then stalls and an enable gap
    do_reset();
    pulse_cnt = 0;
    run_stream(400, 30, 40, lock_acc);
    check("stall_lock_point", 32'(lock_acc), 32'd48);
    check("stall_pulses", 32'(pulse_cnt), 32'd0);

    // random soak: gaps, enable drops, sparse flips and clears
    for (int i = 0; i < 3000; i++) begin
      bit en = ($urandom_range(19) != 0);
      bit v  = ($urandom_range(3) != 0);
      bit cl = ($urandom_range(199) == 0);
      if (en && v) cycle(1'b1, 1'b1, gen_next() ^ ($urandom_range(49) == 0), cl);
      else cycle(en, v, 1'($urandom_range(1)), cl);
    end

    // all-zero and all-one streams must never lock
    do_reset();
    seen_lock = 0;
    for (int i = 0; i < 500; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      if (if16.locked) seen_lock = 1;
    end
    check("zeros_nolock", 32'(seen_lock), 32'd0);
    do_reset();
    seen_lock = 0;
    for (int i = 0; i < 500; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      if (if16.locked) seen_lock = 1;
    end
    check("ones_nolock", 32'(seen_lock), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
